firebird_mc_cu: RTL and testbench

Multi-cycle control sequencer for the Firebird RV32I datapath. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the existing datapath control signals (branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write) plus PC/IR strobes. It handshakes with instruction and data memories that may insert wait states.

---
 rtl/firebird_mc_cu.sv | 166 ++++++++++++++++
 tb/tb_firebird_mc_cu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/firebird_mc_cu.sv
// Multi-cycle control sequencer for the Firebird RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with wait-state memories.
module firebird_mc_cu #(
  parameter int unsigned OPCODE_W = 7,
  parameter int unsigned TMO_CYC  = 15,
  parameter int unsigned TMO_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                reg_write,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_ILL    = 3'd5
  } cls_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state_q, state_nxt;
  cls_t             cls_q, dec_cls;
  logic [TMO_W-1:0] cnt_q;
  logic             timeout, cnt_inc, cnt_clr;

  // Opcode classification, only sampled into cls_q during DECODE.
  always_comb begin
    dec_cls = C_ILL;
    if      (opcode == OPCODE_W'(7'b0110011)) dec_cls = C_R;
    else if (opcode == OPCODE_W'(7'b0010011)) dec_cls = C_I;
    else if (opcode == OPCODE_W'(7'b0000011)) dec_cls = C_LOAD;
    else if (opcode == OPCODE_W'(7'b0100011)) dec_cls = C_STORE;
    else if (opcode == OPCODE_W'(7'b1100011)) dec_cls = C_BRANCH;
  end

  assign timeout = (cnt_q == TMO_LAST);

  // Next state and control outputs; everything held at 0 while in reset.
  always_comb begin
    state_nxt  = S_FETCH;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req  = 1'b1;
          state_nxt = S_FETCH;
          if (imem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
          end
        end
        S_DECODE: state_nxt = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
        S_EXEC: begin
          case (cls_q)
            C_LOAD, C_STORE: begin
              alu_op    = 2'b00;
              alu_src   = 1'b1;
              state_nxt = S_MEM;
            end
            C_BRANCH: begin
              branch   = 1'b1;
              alu_op   = 2'b01;
              pc_write = zero;
              pc_src   = zero;
            end
            C_R: begin
              alu_op    = 2'b10;
              state_nxt = S_WB;
            end
            C_I: begin
              alu_op    = 2'b11;
              alu_src   = 1'b1;
              state_nxt = S_WB;
            end
            default: state_nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          mem_read  = (cls_q == C_LOAD);
          mem_write = (cls_q == C_STORE);
          state_nxt = S_MEM;
          if (dmem_ready) begin
            state_nxt = (cls_q == C_LOAD) ? S_WB : S_FETCH;
          end else if (timeout) begin
            bus_err   = 1'b1;
            state_nxt = S_FETCH;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == C_LOAD);
        end
        S_TRAP:  illegal = 1'b1;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  // A FETCH timeout stays in FETCH, so the counter must also clear on bus_err.
  assign cnt_clr = (state_nxt != state_q) || bus_err;
  assign cnt_inc = ((state_q == S_FETCH) && !imem_ready) ||
                   ((state_q == S_MEM) && !dmem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_DECODE) cls_q <= dec_cls;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_firebird_mc_cu.sv
// Directed bench for firebird_mc_cu: per-cycle state/control vectors against hand-derived expectations.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_firebird_mc_cu;

  logic       clk, rst_n, zero, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       imem_req, dmem_req, ir_write, pc_write, pc_src, branch;
  logic       mem_read, mem_write, mem_to_reg, alu_src, reg_write, illegal, bus_err;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [17:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  // Vector layout: state _ imem_req dmem_req ir_write pc_write pc_src _
  //   branch mem_read mem_write mem_to_reg _ alu_op _ alu_src reg_write illegal bus_err
  localparam logic [17:0] F_OK   = 18'b000_10110_0000_00_0000;
  localparam logic [17:0] F_WAIT = 18'b000_10000_0000_00_0000;
  localparam logic [17:0] DEC    = 18'b001_00000_0000_00_0000;
  localparam logic [17:0] EX_MEM = 18'b010_00000_0000_00_1000;
  localparam logic [17:0] MEM_LD = 18'b011_01000_0100_00_0000;
  localparam logic [17:0] MEM_ST = 18'b011_01000_0010_00_0000;
  localparam logic [17:0] WB_REG = 18'b100_00000_0000_00_0100;
  localparam logic [17:0] WB_LD  = 18'b100_00000_0001_00_0100;

  firebird_mc_cu #(.OPCODE_W(7), .TMO_CYC(15), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  assign obs = {state, imem_req, dmem_req, ir_write, pc_write, pc_src,
                branch, mem_read, mem_write, mem_to_reg, alu_op,
                alu_src, reg_write, illegal, bus_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; opcode = 7'b0110011; zero = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1; n_cmp++;
    if (obs !== 18'b0) begin
      n_err++; $display("FAIL reset got %b want %b", obs, 18'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_timeout();
    logic [17:0] exp;
    imem_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      exp = (i == 14 || i == 29) ? (F_WAIT | 18'd1) : F_WAIT;
      #1; n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL fetch_timeout cyc%0d got %b want %b", i, obs, exp);
      end
      @(negedge clk);
    end
    imem_ready = 1'b1;
  endtask

  task automatic test_r_type();
    logic [17:0] exp [4];
    exp = '{F_OK, DEC, 18'b010_00000_0000_10_0000, WB_REG};
    opcode = 7'b0110011; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL r_type cyc%0d got %b want %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_i_type();
    logic [17:0] exp [4];
    exp = '{F_OK, DEC, 18'b010_00000_0000_11_1000, WB_REG};
    opcode = 7'b0010011; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL i_type cyc%0d got %b want %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic [17:0] exp [8];
    exp = '{F_OK, DEC, EX_MEM, MEM_LD, MEM_LD, MEM_LD, MEM_LD, WB_LD};
    opcode = 7'b0000011; imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dmem_ready = (i == 6);
      #1; n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL load_wait cyc%0d got %b want %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
    dmem_ready = 1'b1;
  endtask

  task automatic test_branch(input logic z);
    logic [17:0] exp [3];
    exp = '{F_OK, DEC, z ? 18'b010_00011_1000_01_0000 : 18'b010_00000_1000_01_0000};
    opcode = 7'b1100011; imem_ready = 1'b1; zero = z;
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL branch_z%0b cyc%0d got %b want %b", z, i, obs, exp[i]);
      end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [17:0] exp [3];
    exp = '{F_OK, DEC, 18'b101_00000_0000_00_0010};
    opcode = 7'b1111111; imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL illegal cyc%0d got %b want %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  // Store whose data ack never comes (timeout) or comes exactly on the 15th MEM cycle.
  task automatic test_store(input logic ack_last);
    logic [17:0] exp;
    opcode = 7'b0100011; imem_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      dmem_ready = ack_last && (i == 17);
      if (i == 0)      exp = F_OK;
      else if (i == 1) exp = DEC;
      else if (i == 2) exp = EX_MEM;
      else             exp = (i == 17 && !ack_last) ? (MEM_ST | 18'd1) : MEM_ST;
      #1; n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL store_ack%0b cyc%0d got %b want %b", ack_last, i, obs, exp);
      end
      @(negedge clk);
    end
    dmem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    logic [17:0] exp [5];
    exp = '{F_OK, DEC, EX_MEM, MEM_LD, MEM_LD};
    opcode = 7'b0000011; imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dmem_ready = 1'b0;
      #1; n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL rst_load cyc%0d got %b want %b", i, obs, exp[i]);
      end
      if (i < 4) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1; n_cmp++;
    if (obs !== 18'b0) begin
      n_err++; $display("FAIL rst_async got %b want %b", obs, 18'b0);
    end
    @(negedge clk);
    dmem_ready = 1'b1; imem_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; n_cmp++;
      if (obs !== F_WAIT) begin
        n_err++; $display("FAIL rst_release cyc%0d got %b want %b", i, obs, F_WAIT);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_timeout();
    test_r_type();
    test_i_type();
    test_load_wait();
    test_branch(1'b1);
    test_branch(1'b0);
    test_illegal();
    test_store(1'b0);
    test_store(1'b1);
    test_r_type();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
